din_unpack: RTL and testbench

Receive-side unpacker for the 48-bit result words produced by the float/fix output formatter. Pops words from the result FIFO, decodes the header, reassembles one- or two-word fixed-point (integer + fraction) or floating-point results into full-width registers, and emits a one-cycle valid pulse per complete result. Protocol violations are flagged and dropped. Sits between the result FIFO and the host-side consumer.

---
 rtl/din_unpack_if.sv | 30 +++
 rtl/din_unpack.sv | 156 +++++++++++++++
 tb/tb_din_unpack.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/din_unpack_if.sv
// rtl/din_unpack_if.sv - result FIFO read side and unpacked result bus
interface din_unpack_if #(
  parameter int INT_WID   = 40,
  parameter int FREC_WID  = 40,
  parameter int FLOAT_WID = 80,
  parameter int DATAIN    = 48
);
  logic                 empty;
  logic [DATAIN-1:0]    datain;
  logic                 rden;
  logic [1:0]           app_out;
  logic [2:0]           size_out;
  logic [INT_WID-1:0]   int_out;
  logic [FREC_WID-1:0]  frec_out;
  logic [FLOAT_WID-1:0] float_out;
  logic                 out_valid;
  logic                 err;

  // FIFO/consumer side
  modport master (
    output empty, datain,
    input  rden, app_out, size_out, int_out, frec_out, float_out, out_valid, err
  );

  // unpacker side
  modport slave (
    input  empty, datain,
    output rden, app_out, size_out, int_out, frec_out, float_out, out_valid, err
  );
endinterface

// File: rtl/din_unpack.sv
// rtl/din_unpack.sv - header decode and one/two-word result reassembly
module din_unpack #(
  parameter int INT_WID   = 40,
  parameter int FREC_WID  = 40,
  parameter int FLOAT_WID = 80,
  parameter int DATAIN    = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  din_unpack_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, HALF = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        wv;
  logic [1:0]  hold_app;
  logic [2:0]  hold_size;
  logic [39:0] hold_p;

  logic [DATAIN-1:0] word;
  logic [1:0]  app;
  logic [2:0]  size;
  logic [2:0]  idx;
  logic [39:0] p;
  logic        hdr_ok;
  logic        pair_match;

  logic                 do_out, do_err, do_latch;
  logic [INT_WID-1:0]   res_int;
  logic [FREC_WID-1:0]  res_frec;
  logic [FLOAT_WID-1:0] res_float;

  // pop whenever the FIFO has data; held off while in reset
  assign bus.rden = rst_n & ~bus.empty;

  assign word = bus.datain;
  assign app  = word[47:46];
  assign size = word[45:43];
  assign idx  = word[42:40];
  assign p    = word[39:0];

  // header legality: known app, size 1..3, idx consistent with size
  always_comb begin
    hdr_ok = ((app == 2'b01) || (app == 2'b10)) &&
             (size >= 3'd1) && (size <= 3'd3) &&
             (((idx == 3'b000) && (size == 3'd1)) ||
              (((idx == 3'b001) || (idx == 3'b010)) && (size != 3'd1)));
    pair_match = (state == HALF) && (app == hold_app) && (size == hold_size);
  end

  // state register and word-valid flag (datain is valid the cycle after rden)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wv    <= 1'b0;
    end else begin
      state <= state_nxt;
      wv    <= bus.rden;
    end
  end

  // next state: a legal first half parks in HALF, everything else returns to IDLE
  always_comb begin
    state_nxt = state;
    if (wv) begin
      if (hdr_ok && (idx == 3'b001))
        state_nxt = HALF;
      else
        state_nxt = IDLE;
    end
  end

  // output decode: classify the word and assemble the full-width result
  always_comb begin
    do_out    = 1'b0;
    do_err    = 1'b0;
    do_latch  = 1'b0;
    res_int   = '0;
    res_frec  = '0;
    res_float = '0;
    if (wv) begin
      if (!hdr_ok) begin
        do_err = 1'b1;
      end else if (idx == 3'b000) begin
        // single word; an abandoned half is flagged in the same cycle
        do_out = 1'b1;
        do_err = (state == HALF);
        if (app == 2'b01) begin
          res_int  = {{(INT_WID-16){p[39]}}, p[39:24]};
          res_frec = {{(FREC_WID-16){1'b0}}, p[23:8]};
        end else begin
          res_float = FLOAT_WID'(p[39:8]);
        end
      end else if (idx == 3'b001) begin
        do_latch = 1'b1;
        do_err   = (state == HALF);
      end else if (pair_match) begin
        do_out = 1'b1;
        if (app == 2'b01) begin
          if (size == 3'd2) begin
            res_int  = {{(INT_WID-32){hold_p[39]}}, hold_p[39:8]};
            res_frec = {{(FREC_WID-32){1'b0}}, p[39:8]};
          end else begin
            res_int  = INT_WID'(hold_p);
            res_frec = FREC_WID'(p);
          end
        end else begin
          if (size == 3'd2)
            res_float = FLOAT_WID'({hold_p, p[39:16]});
          else
            res_float = FLOAT_WID'({hold_p, p});
        end
      end else begin
        do_err = 1'b1;
      end
    end
  end

  // first-half holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_app  <= 2'b00;
      hold_size <= 3'd0;
      hold_p    <= '0;
    end else if (do_latch) begin
      hold_app  <= app;
      hold_size <= size;
      hold_p    <= p;
    end
  end

  // registered result outputs; fields hold between valid pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.err       <= 1'b0;
      bus.app_out   <= 2'b00;
      bus.size_out  <= 3'd0;
      bus.int_out   <= '0;
      bus.frec_out  <= '0;
      bus.float_out <= '0;
    end else begin
      bus.out_valid <= do_out;
      bus.err       <= do_err;
      if (do_out) begin
        bus.app_out   <= app;
        bus.size_out  <= size;
        bus.int_out   <= res_int;
        bus.frec_out  <= res_frec;
        bus.float_out <= res_float;
      end
    end
  end

endmodule

// File: tb/tb_din_unpack.sv
// tb/tb_din_unpack.sv - directed self-checking bench for din_unpack
module tb_din_unpack;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  logic [47:0] pend = '0;

  din_unpack_if #(.INT_WID(40), .FREC_WID(40), .FLOAT_WID(80), .DATAIN(48)) bus ();

  din_unpack #(.INT_WID(40), .FREC_WID(40), .FLOAT_WID(80), .DATAIN(48)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one cycle of FIFO behaviour: data popped last cycle appears on datain now
  task automatic step(input bit have, input logic [47:0] w);
    @(negedge clk);
    bus.datain = pend;
    bus.empty  = !have;
    pend       = w;
  endtask

  initial begin
    bus.empty  = 1'b1;
    bus.datain = '0;

    // reset: rden blocked even with data present, outputs cleared
    @(negedge clk);
    bus.empty = 1'b0;
    #1;
    chk("rst_rden", 80'(bus.rden), 80'd0);
    chk("rst_valid", 80'(bus.out_valid), 80'd0);
    chk("rst_int", 80'(bus.int_out), 80'd0);
    chk("rst_float", bus.float_out, 80'd0);
    bus.empty = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    bus.empty = 1'b0;
    #1;
    chk("rden_follow", 80'(bus.rden), 80'd1);
    bus.empty = 1'b1;

    // fixed size 1
    step(1, 48'h48_1234_5678_00);
    step(0, '0);
    step(0, '0);
    chk("fx1_valid", 80'(bus.out_valid), 80'd1);
    chk("fx1_err", 80'(bus.err), 80'd0);
    chk("fx1_int", 80'(bus.int_out), 80'h0000001234);
    chk("fx1_frec", 80'(bus.frec_out), 80'h0000005678);
    chk("fx1_float", bus.float_out, 80'd0);
    chk("fx1_app", 80'(bus.app_out), 80'd1);
    chk("fx1_size", 80'(bus.size_out), 80'd1);
    step(0, '0);
    chk("fx1_pulse", 80'(bus.out_valid), 80'd0);

    // fixed size 3 pair with a 5-cycle empty gap
    step(1, 48'h59_0000000007);
    for (int i = 0; i < 5; i++) begin
      step(0, '0);
      chk("fx3_gap_valid", 80'(bus.out_valid | bus.err), 80'd0);
    end
    step(1, 48'h5A_8000000000);
    step(0, '0);
    step(0, '0);
    chk("fx3_valid", 80'(bus.out_valid), 80'd1);
    chk("fx3_int", 80'(bus.int_out), 80'h0000000007);
    chk("fx3_frec", 80'(bus.frec_out), 80'h8000000000);
    chk("fx3_size", 80'(bus.size_out), 80'd3);

    // float size 2, back-to-back words
    step(1, 48'h91_AABBCCDDEE);
    step(1, 48'h92_1122330000);
    step(0, '0);
    chk("fl2_first_quiet", 80'(bus.out_valid), 80'd0);
    step(0, '0);
    chk("fl2_valid", 80'(bus.out_valid), 80'd1);
    chk("fl2_float", bus.float_out, 80'h0000_AABBCCDDEE_112233);
    chk("fl2_int", 80'(bus.int_out), 80'd0);
    chk("fl2_frec", 80'(bus.frec_out), 80'd0);

    // second half while idle
    step(1, 48'h5A_0000000000);
    step(0, '0);
    step(0, '0);
    chk("idle2nd_err", 80'(bus.err), 80'd1);
    chk("idle2nd_valid", 80'(bus.out_valid), 80'd0);
    chk("idle2nd_hold", bus.float_out, 80'h0000_AABBCCDDEE_112233);

    // app 11
    step(1, 48'hC8_0000000000);
    step(0, '0);
    step(0, '0);
    chk("app11_err", 80'(bus.err), 80'd1);
    chk("app11_valid", 80'(bus.out_valid), 80'd0);

    // size 2 first then size 3 second, then a single proves IDLE
    step(1, 48'h51_0000000001);
    step(1, 48'h5A_0000000000);
    step(0, '0);
    chk("mism_first_quiet", 80'(bus.err), 80'd0);
    step(0, '0);
    chk("mism_err", 80'(bus.err), 80'd1);
    chk("mism_valid", 80'(bus.out_valid), 80'd0);
    step(1, 48'h48_0001_0002_00);
    step(0, '0);
    step(0, '0);
    chk("post_mism_valid", 80'(bus.out_valid), 80'd1);
    chk("post_mism_err", 80'(bus.err), 80'd0);
    chk("post_mism_int", 80'(bus.int_out), 80'd1);
    chk("post_mism_frec", 80'(bus.frec_out), 80'd2);

    // half pending, then a float single word
    step(1, 48'h59_0000000003);
    step(1, 48'h88_DEADBEEF00);
    step(0, '0);
    step(0, '0);
    chk("halfsgl_err", 80'(bus.err), 80'd1);
    chk("halfsgl_valid", 80'(bus.out_valid), 80'd1);
    chk("halfsgl_float", bus.float_out, 80'hDEADBEEF);
    chk("halfsgl_int", 80'(bus.int_out), 80'd0);
    chk("halfsgl_app", 80'(bus.app_out), 80'd2);

    // sign extension of negative fixed size 1 integer
    step(1, 48'h48_8001_0000_00);
    step(0, '0);
    step(0, '0);
    chk("fx1_neg_int", 80'(bus.int_out), 80'hFFFFFF8001);

    // 16 back-to-back fixed singles
    pulses = 0;
    for (int k = 0; k < 18; k++) begin
      step(k < 16, {8'h48, 16'(k), 16'(k + 16'h100), 8'h00});
      if (bus.out_valid) pulses++;
      if (k >= 2) begin
        chk("strm_valid", 80'(bus.out_valid), 80'd1);
        chk("strm_int", 80'(bus.int_out), 80'(k - 2));
        chk("strm_frec", 80'(bus.frec_out), 80'(k - 2 + 16'h100));
      end
    end
    step(0, '0);
    if (bus.out_valid) pulses++;
    chk("strm_pulses", 80'(pulses), 80'd16);

    // reset while a half is pending
    step(1, 48'h59_0000000005);
    step(0, '0);
    step(0, '0);
    chk("pre_rst_quiet", 80'(bus.out_valid | bus.err), 80'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_int", 80'(bus.int_out), 80'd0);
    chk("midrst_frec", 80'(bus.frec_out), 80'd0);
    chk("midrst_size", 80'(bus.size_out), 80'd0);
    step(0, '0);
    rst_n = 1'b1;
    step(1, 48'h5A_8000000000);
    step(0, '0);
    step(0, '0);
    chk("postrst_valid", 80'(bus.out_valid), 80'd0);
    chk("postrst_err", 80'(bus.err), 80'd1);
    chk("postrst_int", 80'(bus.int_out), 80'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
